// File: rtl/ps2_kbd_ascii_pkg.sv
// ps2_kbd_ascii_pkg: scancode constants and decoder state encoding shared by the keyboard front end
package ps2_kbd_ascii_pkg;
  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;
  localparam logic [7:0] PS2_CAPS   = 8'h58;
  typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} dec_state_e;
endpackage

// File: rtl/ps2_scan2ascii.sv
// ps2_scan2ascii: combinational set-2 make code to US ASCII lookup, 0 for unmapped codes
module ps2_scan2ascii (
  input  logic [7:0] scancode,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);
  logic [7:0]  lc;
  logic [15:0] us;
  always_comb begin
    lc = 8'h00;
    us = 16'h0000;
    case (scancode)
      8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
      8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
      8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
      8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
      8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
      8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
      8'h35: lc = "y";  8'h1A: lc = "z";
      8'h16: us = "1!"; 8'h1E: us = "2@"; 8'h26: us = "3#"; 8'h25: us = "4$";
      8'h2E: us = "5%"; 8'h36: us = "6^"; 8'h3D: us = "7&"; 8'h3E: us = "8*";
      8'h46: us = "9("; 8'h45: us = "0)";
      8'h0E: us = "`~"; 8'h4E: us = "-_"; 8'h55: us = "=+"; 8'h54: us = "[{";
      8'h5B: us = "]}"; 8'h5D: us = {8'h5C, "|"}; 8'h4C: us = ";:"; 8'h52: us = {"'", 8'h22};
      8'h41: us = ",<"; 8'h49: us = ".>"; 8'h4A: us = "/?";
      8'h29: us = 16'h2020; 8'h5A: us = 16'h0D0D; 8'h66: us = 16'h0808;
      8'h0D: us = 16'h0909; 8'h76: us = 16'h1B1B;
      default: ;
    endcase
    ascii = lc != 8'h00 ? ((shift ^ caps) ? lc - 8'h20 : lc) : (shift ? us[7:0] : us[15:8]);
  end
endmodule

// File: rtl/ps2_kbd_ascii.sv
// ps2_kbd_ascii: PS/2 set-2 receiver, make/break decoder and ASCII FIFO with level interrupt
module ps2_kbd_ascii
  import ps2_kbd_ascii_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int TIMEOUT_US = 100,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] kbd_data,
  output logic       kbd_int,
  input  logic       kbd_int_ack,
  output logic       overflow,
  output logic       frame_err
);
  localparam int TO_CYC = CLK_FREQ / 1000000 * TIMEOUT_US;
  localparam int TW = $clog2(TO_CYC + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [2:0] ck_q, ck_d;
  logic [1:0] dt_q, dt_d;
  logic fall_q, fall_d, bit_q, bit_d;
  logic [3:0] cnt_q, cnt_d;
  logic [8:0] sr_q, sr_d;
  logic [TW-1:0] to_q, to_d;
  logic code_valid_q, code_valid_d, err_q, err_d;
  logic [7:0] code_q, code_d;
  dec_state_e st_q, st_d;
  logic shift_q, shift_d, caps_q, caps_d, is_make, is_brk;
  logic push_q, push_d;
  logic [7:0] push_data_q, push_data_d, ascii;
  logic ack_q, ack_d, ack_prev_q, ack_prev_d, ovf_q, ovf_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0] mem_q [FIFO_DEPTH], mem_d [FIFO_DEPTH];
  logic empty, full, pop, push_ok;

  ps2_scan2ascii u_xlate (.scancode(code_q), .shift(shift_q), .caps(caps_q), .ascii(ascii));

  // ck_q = {previous, sync2, sync1}; fall and sampled bit are registered together
  always_comb begin
    ck_d = {ck_q[1:0], ps2_clk};
    dt_d = {dt_q[0], ps2_data};
    fall_d = ck_q[2] & ~ck_q[1];
    bit_d = dt_q[1];
  end

  always_comb begin
    cnt_d = cnt_q;
    sr_d = sr_q;
    to_d = cnt_q != 4'd0 ? to_q + 1'b1 : '0;
    code_valid_d = 1'b0;
    code_d = code_q;
    err_d = 1'b0;
    if (fall_q) begin
      to_d = '0;
      if (cnt_q == 4'd0) cnt_d = {3'b000, ~bit_q};
      else if (cnt_q == 4'd10) begin
        cnt_d = 4'd0;
        code_d = sr_q[7:0];
        code_valid_d = bit_q & ^sr_q;
        err_d = ~(bit_q & ^sr_q);
      end else begin
        sr_d = {bit_q, sr_q[8:1]};
        cnt_d = cnt_q + 4'd1;
      end
    end else if (to_q == TO_CYC[TW-1:0]) begin
      cnt_d = 4'd0;
      to_d = '0;
      err_d = 1'b1;
    end
  end

  always_comb begin
    st_d = st_q;
    shift_d = shift_q;
    caps_d = caps_q;
    is_make = 1'b0;
    is_brk = 1'b0;
    if (code_valid_q) begin
      is_make = st_q == ST_IDLE && code_q != PS2_BREAK && code_q != PS2_EXT;
      is_brk = st_q == ST_BRK;
      st_d = st_q == ST_IDLE ? (code_q == PS2_BREAK ? ST_BRK : code_q == PS2_EXT ? ST_EXT : ST_IDLE)
           : (st_q == ST_EXT && code_q == PS2_BREAK) ? ST_EXT_BRK : ST_IDLE;
      if ((code_q == PS2_LSHIFT || code_q == PS2_RSHIFT) && (is_make || is_brk)) shift_d = is_make;
      if (code_q == PS2_CAPS && is_make) caps_d = ~caps_q;
    end
    push_d = is_make && ascii != 8'h00;
    push_data_d = ascii;
  end

  // a pop frees the slot first, so a push into a full queue on the same cycle is kept
  always_comb begin
    ack_d = kbd_int_ack;
    ack_prev_d = ack_q;
    empty = wr_q == rd_q;
    full = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
    pop = ack_q & ~ack_prev_q & ~empty;
    push_ok = push_q & (~full | pop);
    ovf_d = ovf_q | (push_q & full & ~pop);
    mem_d = mem_q;
    if (push_ok) mem_d[wr_q[AW-1:0]] = push_data_q;
    wr_d = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    kbd_int = ~empty;
    kbd_data = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
    overflow = ovf_q;
    frame_err = err_q;
  end

  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      ck_q <= '0; dt_q <= '0; fall_q <= 1'b0; bit_q <= 1'b0;
      cnt_q <= '0; sr_q <= '0; to_q <= '0;
      code_valid_q <= 1'b0; code_q <= '0; err_q <= 1'b0;
      st_q <= ST_IDLE; shift_q <= 1'b0; caps_q <= 1'b0;
      push_q <= 1'b0; push_data_q <= '0;
      ack_q <= 1'b0; ack_prev_q <= 1'b0; ovf_q <= 1'b0;
      wr_q <= '0; rd_q <= '0; mem_q <= '{default: '0};
    end else begin
      ck_q <= ck_d; dt_q <= dt_d; fall_q <= fall_d; bit_q <= bit_d;
      cnt_q <= cnt_d; sr_q <= sr_d; to_q <= to_d;
      code_valid_q <= code_valid_d; code_q <= code_d; err_q <= err_d;
      st_q <= st_d; shift_q <= shift_d; caps_q <= caps_d;
      push_q <= push_d; push_data_q <= push_data_d;
      ack_q <= ack_d; ack_prev_q <= ack_prev_d; ovf_q <= ovf_d;
      wr_q <= wr_d; rd_q <= rd_d; mem_q <= mem_d;
    end
  end
endmodule

// File: tb/tb_ps2_kbd_ascii.sv
// tb_ps2_kbd_ascii: directed and randomized PS/2 frames checked against a key-event model of the keyboard
module tb_ps2_kbd_ascii;
  localparam int H = 10;
  localparam int DEPTH = 4;
  localparam byte unsigned LC[26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
                                      8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  localparam byte unsigned DC[10] = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
  localparam byte unsigned PC[11] = '{8'h0E,8'h4E,8'h55,8'h54,8'h5B,8'h5D,8'h4C,8'h52,8'h41,8'h49,8'h4A};
  localparam byte unsigned CC[5] = '{8'h29,8'h5A,8'h66,8'h0D,8'h76};
  localparam byte unsigned CA[5] = '{8'h20,8'h0D,8'h08,8'h09,8'h1B};

  logic clk50M = 0, rst = 0, ps2_clk = 1, ps2_data = 1, kbd_int_ack = 0;
  logic [7:0] kbd_data;
  logic kbd_int, overflow, frame_err;
  int checks = 0, errors = 0, err_pulses = 0, exp_err = 0;
  byte unsigned q[$], pool[$];
  byte unsigned lo[256], hi[256];
  bit letter[256];
  bit m_shift, m_caps, m_brk, m_ext, m_ovf;

  always #10 clk50M = ~clk50M;
  always @(negedge clk50M) if (frame_err === 1'b1) err_pulses++;

  ps2_kbd_ascii #(.CLK_FREQ(1000000), .TIMEOUT_US(100), .FIFO_DEPTH(DEPTH)) dut (
    .clk50M(clk50M), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .kbd_data(kbd_data),
    .kbd_int(kbd_int), .kbd_int_ack(kbd_int_ack), .overflow(overflow), .frame_err(frame_err));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic init_tbl();
    string l = "abcdefghijklmnopqrstuvwxyz", d = "1234567890", ds = "!@#$%^&*()";
    string p = "`-=[]?;',./", ps = "~_+{}|:?<>?";
    p[5] = 8'h5C;
    ps[7] = 8'h22;
    for (int i = 0; i < 26; i++) begin lo[LC[i]] = l[i]; hi[LC[i]] = l[i] - 8'd32; letter[LC[i]] = 1; pool.push_back(LC[i]); end
    for (int i = 0; i < 10; i++) begin lo[DC[i]] = d[i]; hi[DC[i]] = ds[i]; pool.push_back(DC[i]); end
    for (int i = 0; i < 11; i++) begin lo[PC[i]] = p[i]; hi[PC[i]] = ps[i]; pool.push_back(PC[i]); end
    for (int i = 0; i < 5; i++) begin lo[CC[i]] = CA[i]; hi[CC[i]] = CA[i]; pool.push_back(CC[i]); end
    foreach (pool[i]) if (i < 0) pool.delete(i);
    pool.push_back(8'h12); pool.push_back(8'h59); pool.push_back(8'h58); pool.push_back(8'h05);
    pool.push_back(8'h75); pool.push_back(8'hE0); pool.push_back(8'hE0);
    for (int i = 0; i < 8; i++) pool.push_back(8'hF0);
  endtask

  task automatic model_code(input byte unsigned c);
    byte unsigned a;
    if (m_ext) begin
      if (!m_brk && c == 8'hF0) m_brk = 1;
      else begin m_ext = 0; m_brk = 0; end
    end else if (m_brk) begin
      m_brk = 0;
      if (c == 8'h12 || c == 8'h59) m_shift = 0;
    end else if (c == 8'hF0) m_brk = 1;
    else if (c == 8'hE0) m_ext = 1;
    else if (c == 8'h12 || c == 8'h59) m_shift = 1;
    else if (c == 8'h58) m_caps = ~m_caps;
    else begin
      a = letter[c] ? ((m_shift ^ m_caps) ? hi[c] : lo[c]) : (m_shift ? hi[c] : lo[c]);
      if (a != 0) begin
        if (q.size() < DEPTH) q.push_back(a);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk50M);
    #1;
  endtask

  function automatic logic [10:0] frame(input byte unsigned c, input bit bad);
    return {1'b1, (~^c) ^ bad, c, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      wait_cyc(H);
      ps2_clk = 0;
      wait_cyc(H);
      ps2_clk = 1;
    end
    ps2_data = 1;
  endtask

  task automatic send(input byte unsigned c, input bit bad = 0);
    send_bits(frame(c, bad), 11);
    if (bad) exp_err++;
    else model_code(c);
    wait_cyc(4);
  endtask

  task automatic check_head(input string tag);
    check({tag, " int"}, kbd_int, q.size() != 0);
    check({tag, " data"}, kbd_data, q.size() != 0 ? q[0] : 8'h00);
    check({tag, " ovf"}, overflow, m_ovf);
    check({tag, " err"}, err_pulses, exp_err);
  endtask

  task automatic pop();
    kbd_int_ack = 1;
    wait_cyc(2);
    if (q.size() != 0) void'(q.pop_front());
    kbd_int_ack = 0;
    wait_cyc(1);
  endtask

  task automatic do_reset();
    rst = 0;
    q.delete();
    {m_shift, m_caps, m_brk, m_ext, m_ovf} = '0;
    wait_cyc(3);
    check("rst data", kbd_data, 8'h00);
    check("rst int", kbd_int, 1'b0);
    check("rst ovf", overflow, 1'b0);
    check("rst err", frame_err, 1'b0);
    rst = 1;
    wait_cyc(2);
  endtask

  initial begin
    byte unsigned seq[$];
    init_tbl();
    do_reset();
    send_bits(frame(8'h1C, 0), 10);
    wait_cyc(H);
    ps2_clk = 0;
    wait_cyc(5);
    check("lat early int", kbd_int, 1'b0);
    wait_cyc(1);
    check("lat int", kbd_int, 1'b1);
    check("lat data", kbd_data, 8'h61);
    wait_cyc(H);
    ps2_clk = 1;
    model_code(8'h1C);
    wait_cyc(H);
    pop();
    check_head("ack");
    seq = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h16};
    foreach (seq[i]) send(seq[i]);
    check("shift A", kbd_data, 8'h41);
    pop();
    check("shift 1", kbd_data, 8'h31);
    pop();
    check_head("shift end");
    seq = '{8'h58, 8'hF0, 8'h58, 8'h1C, 8'h12, 8'h1C, 8'hF0, 8'h12, 8'h58, 8'hF0, 8'h58};
    foreach (seq[i]) send(seq[i]);
    check("caps A", kbd_data, 8'h41);
    pop();
    check("caps a", kbd_data, 8'h61);
    pop();
    check_head("caps end");
    send(8'h1C, 1);
    check_head("parity");
    send(8'h32);
    check("after parity", kbd_data, 8'h62);
    pop();
    send_bits(frame(8'h1C, 0), 5);
    wait_cyc(200);
    exp_err++;
    check_head("timeout");
    send(8'h1C);
    check("after timeout", kbd_data, 8'h61);
    pop();
    seq = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
    foreach (seq[i]) send(seq[i]);
    check("ovf set", overflow, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("ovf order", kbd_data, 8'h61 + i);
      pop();
    end
    pop();
    check_head("ovf drained");
    seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    foreach (seq[i]) send(seq[i]);
    check_head("ext");
    send_bits(frame(8'h1C, 0), 5);
    do_reset();
    send(8'h32);
    check("post rst", kbd_data, 8'h62);
    pop();
    check_head("post rst end");
    for (int it = 0; it < 120; it++) begin
      int r = $urandom_range(0, 9);
      if (r < 7) send(pool[$urandom_range(0, pool.size() - 1)]);
      else if (r == 7) send(pool[$urandom_range(0, pool.size() - 1)], 1);
      else pop();
      check_head("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
